// File: rtl/tone_bank.sv
// Multi-channel square-wave tone generator: per-channel half-period register,
// down-counter and phase bit, all stepped by a shared prescaler tick.
module tone_lane #(
  parameter int W       = 10,
  parameter bit RESTART = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic         wr_sel,
  input  logic [W-1:0] wr_data,
  output logic         out
);
  logic [W-1:0] per, cnt;
  logic         ph, run;

  // Periods of 0 and 1 park the channel: flat high output, counter parked at 0.
  assign run = (per > W'(1));
  assign out = run ? ph : 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      per <= '0;
      cnt <= '0;
      ph  <= 1'b0;
    end else begin
      if (run) begin
        if (tick) begin
          if (cnt == '0) begin
            cnt <= per - W'(1);
            ph  <= ~ph;
          end else begin
            cnt <= cnt - W'(1);
          end
        end
      end else begin
        cnt <= '0;
      end
      // Later assignments win, so a restarting write overrides the tick step.
      if (wr_sel) begin
        per <= wr_data;
        if (RESTART) begin
          cnt <= '0;
          ph  <= 1'b0;
        end
      end
    end
  end
endmodule

module tone_bank #(
  parameter int CHANNELS         = 3,
  parameter int COUNTER_BITS     = 10,
  parameter bit RESTART_ON_WRITE = 1'b0,
  localparam int ADDR_BITS       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tick,
  input  logic                    wr_en,
  input  logic [ADDR_BITS-1:0]    wr_addr,
  input  logic [COUNTER_BITS-1:0] wr_data,
  output logic [CHANNELS-1:0]     out
);
  logic [CHANNELS-1:0] wr_sel;

  // Out-of-range addresses never match a lane, so such writes are dropped.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    assign wr_sel[i] = wr_en && (wr_addr == ADDR_BITS'(i));

    tone_lane #(
      .W       (COUNTER_BITS),
      .RESTART (RESTART_ON_WRITE)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .tick    (tick),
      .wr_sel  (wr_sel[i]),
      .wr_data (wr_data),
      .out     (out[i])
    );
  end
endmodule
